io_input_conditioner: RTL and testbench
=======================================

Name: io_input_conditioner

Overview:
- Upstream front end of the LSU input path. It takes raw board switches and push-buttons and produces the `i_io_sw` and `i_io_btn` words that the LSU reads.
- Each input bit gets a 2-flop synchroniser and a per-bit stable-time debouncer. Buttons are converted from active-low to active-high.
- For each button, a press-toggle bit lets polling software detect presses without a clear strobe.

Parameters:
- N_SW, 10, number of switch inputs (1..32).
- N_BTN, 4, number of button inputs (1..14).
- DEBOUNCE_CYCLES, 500000, stable cycles required before a debounced bit changes (10 ms at 50 MHz); legal range ≥1.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous, active-low reset.
- i_sw_raw  input  N_SW  raw switch levels, asynchronous, 1 = on.
- i_btn_raw_n  input  N_BTN  raw buttons, asynchronous, active-low (0 = pressed).
- o_io_sw  output  32  {zeros, debounced switches}; feeds LSU `i_io_sw`.
- o_io_btn  output  32  {zeros, toggle[N_BTN-1:0], level[N_BTN-1:0]}; feeds LSU `i_io_btn`.
- o_btn_press  output  N_BTN  one-cycle pulse per debounced press (debug / interrupt use).

Behaviour:
- Reset is asynchronous on `i_rst` = 0; release is used synchronously by all flops.
- Reset values:
  - Switch synchroniser flops = 0.
  - Button synchroniser flops = 1, i.e. released.
  - All debounced states = 0.
  - All counters = 0.
  - Toggles = 0.
  - `o_io_sw`, `o_io_btn`, `o_btn_press` = 0.
- Synchroniser: s1 <= raw; s2 <= s1, per bit. Button inversion is applied after s2: b = ~s2.
- Debouncer, per bit, with state `st` and counter `cnt` (width $clog2(DEBOUNCE_CYCLES)+1). At each rising edge:
  - s == st: cnt <= 0.
  - s != st and cnt == DEBOUNCE_CYCLES-1: st <= s, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- Latency:
  - A raw change made just before edge 1 and held steady updates the output at edge DEBOUNCE_CYCLES+2. The synchroniser accounts for 2 edges, the debouncer for the rest.
  - DEBOUNCE_CYCLES = 1 gives a fixed 3-edge delay.
- Glitch rejection: any excursion with s != st for fewer than DEBOUNCE_CYCLES consecutive sampled cycles is discarded. The counter restarts from 0 on the next differing cycle.
- Bits are independent. Simultaneous changes on several bits each follow their own counter, with no interaction.
- Press detect: when a button's debounced level goes 0→1 at an edge:
  - its toggle bit flips at the same edge;
  - `o_btn_press` for that bit is 1 for exactly the following cycle.
- Release (1→0) does not flip the toggle and produces no pulse.
- Output packing:
  - `o_io_sw[N_SW-1:0]` = switch states; upper bits are 0.
  - `o_io_btn[N_BTN-1:0]` = button levels.
  - `o_io_btn[2*N_BTN-1:N_BTN]` = toggles; upper bits are 0.
- All outputs are registered; there is no combinational path from raw inputs to outputs.
- Counter wrap-around is impossible: the counter is cleared on reaching DEBOUNCE_CYCLES-1, and never exceeds it.
- Reset mid-count: all counters and states return to reset values at once. After release, a button held pressed is re-qualified from zero and produces one press pulse and one toggle.
- Toggle wraps naturally (1→0 on the next press); it is a parity bit, not a counter.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4, N_SW=10, N_BTN=4, `i_sw_raw`=0, `i_btn_raw_n`=4'hF -> `o_io_sw`=0, `o_io_btn`=0, `o_btn_press`=0. Then assert reset with arbitrary raw inputs -> all outputs 0 within the same cycle (asynchronous).
- `i_sw_raw` 0→10'h2A5 held steady -> `o_io_sw` = 32'h2A5 exactly at edge 6 after the change, and still 0 at edge 5.
- Switch bit 0 pulsed high for 3 cycles, then low -> `o_io_sw` stays 0 throughout. Then held high for 4+ cycles -> bit 0 rises at edge 6.
- Button 2 pressed (`i_btn_raw_n`=4'hB) and held -> at edge 6, `o_io_btn` = 32'h0000_0044. `o_btn_press`=4'b0100 for one cycle, then 0.
- Button 2 released, then pressed again (each ≥6 cycles) -> release gives `o_io_btn`=32'h40 with no pulse; second press gives `o_io_btn`=32'h04 (toggle back to 0) with one press pulse.
- Buttons 0 and 3 pressed on the same cycle while switch 9 bounces every 2 cycles -> both buttons qualify at edge 6 with `o_btn_press`=4'b1001 in the same cycle. Switch 9 never changes `o_io_sw`. Asserting `i_rst` mid-count returns all outputs to 0.

Source files
------------

// File: rtl/io_input_conditioner.sv
// io_input_conditioner: synchronises, debounces and packs board switches/buttons for the LSU.
module io_input_conditioner #(
  parameter int N_SW            = 10,
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SW-1:0]  i_sw_raw,
  input  logic [N_BTN-1:0] i_btn_raw_n,
  output logic [31:0]      o_io_sw,
  output logic [31:0]      o_io_btn,
  output logic [N_BTN-1:0] o_btn_press
);
  localparam int N  = N_SW + N_BTN;
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [N_SW-1:0]  sw_s1_q, sw_s2_q;
  logic [N_BTN-1:0] btn_s1_q, btn_s2_q;
  logic [N-1:0]     s, st_q, st_d;
  logic [CW-1:0]    cnt_q [N];
  logic [CW-1:0]    cnt_d [N];
  logic [N_BTN-1:0] tgl_q, tgl_d, press_q, press_d;
  // Buttons and switches share one debouncer vector; buttons sit in the top bits, already active-high.
  assign s = {~btn_s2_q, sw_s2_q};
  always_comb begin
    st_d = st_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = (s[i] == st_q[i] || cnt_q[i] == CNT_MAX) ? '0 : cnt_q[i] + 1'b1;
      st_d[i]  = (s[i] != st_q[i] && cnt_q[i] == CNT_MAX) ? s[i] : st_q[i];
    end
    press_d = st_d[N-1:N_SW] & ~st_q[N-1:N_SW];
    tgl_d   = tgl_q ^ press_d;
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '1;
      btn_s2_q <= '1;
      st_q     <= '0;
      tgl_q    <= '0;
      press_q  <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      sw_s1_q  <= i_sw_raw;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= i_btn_raw_n;
      btn_s2_q <= btn_s1_q;
      st_q     <= st_d;
      tgl_q    <= tgl_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end
  assign o_io_sw     = 32'(st_q[N_SW-1:0]);
  assign o_io_btn    = 32'({tgl_q, st_q[N-1:N_SW]});
  assign o_btn_press = press_q;
endmodule

// File: tb/tb_io_input_conditioner.sv
// tb_io_input_conditioner: directed and random checks of the input conditioner against a history-window model.
module tb_io_input_conditioner;
  localparam int NS = 10;
  localparam int NB = 4;
  localparam int D  = 4;
  logic i_clk = 0;
  logic i_rst;
  logic [NS-1:0] i_sw_raw;
  logic [NB-1:0] i_btn_raw_n;
  logic [31:0] o_io_sw, o_io_btn;
  logic [NB-1:0] o_btn_press;
  int checks = 0;
  int errors = 0;
  logic [NS+NB-1:0] hist[$];
  logic [NS+NB-1:0] st_m;
  logic [NB-1:0] tgl_m, press_m;
  logic [NS-1:0] cur_sw;
  logic [NB-1:0] cur_btn;

  io_input_conditioner #(.N_SW(NS), .N_BTN(NB), .DEBOUNCE_CYCLES(D)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sw_raw(i_sw_raw), .i_btn_raw_n(i_btn_raw_n),
    .o_io_sw(o_io_sw), .o_io_btn(o_io_btn), .o_btn_press(o_btn_press)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [NS+NB-1:0] s_at(input int idx);
    return (idx < 0) ? '0 : hist[idx];
  endfunction

  // A bit adopts a new level once its last D synchronised samples all agree on it.
  task automatic model_edge();
    int e;
    logic [NS+NB-1:0] cur, w;
    bit all;
    e = hist.size();
    cur = s_at(e - 3);
    press_m = '0;
    for (int b = 0; b < NS + NB; b++) begin
      all = 1;
      for (int k = 0; k < D; k++) begin
        w = s_at(e - 3 - k);
        if (w[b] != cur[b]) all = 0;
      end
      if (all && cur[b] != st_m[b]) begin
        st_m[b] = cur[b];
        if (b >= NS && cur[b]) begin
          tgl_m[b-NS] = ~tgl_m[b-NS];
          press_m[b-NS] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("sw", o_io_sw, 32'(st_m[NS-1:0]));
    chk("btn", o_io_btn, 32'({tgl_m, st_m[NS+NB-1:NS]}));
    chk("press", 32'(o_btn_press), 32'(press_m));
  endtask

  task automatic step(input logic [NS-1:0] sw, input logic [NB-1:0] btn);
    @(negedge i_clk);
    i_sw_raw = sw;
    i_btn_raw_n = btn;
    @(posedge i_clk);
    #1;
    hist.push_back({~btn, sw});
    model_edge();
    check_all();
  endtask

  task automatic steps(input int n, input logic [NS-1:0] sw, input logic [NB-1:0] btn);
    for (int i = 0; i < n; i++) step(sw, btn);
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #3;
    i_rst = 0;
    #1;
    chk("rst_sw", o_io_sw, 32'h0);
    chk("rst_btn", o_io_btn, 32'h0);
    chk("rst_press", 32'(o_btn_press), 32'h0);
    hist.delete();
    st_m = '0;
    tgl_m = '0;
    press_m = '0;
    @(posedge i_clk);
    #2;
    i_rst = 1;
  endtask

  initial begin
    i_rst = 1;
    i_sw_raw = '0;
    i_btn_raw_n = '1;
    st_m = '0;
    tgl_m = '0;
    press_m = '0;
    #1 i_rst = 0;
    #1;
    chk("init_sw", o_io_sw, 32'h0);
    chk("init_btn", o_io_btn, 32'h0);
    chk("init_press", 32'(o_btn_press), 32'h0);
    @(posedge i_clk);
    #2 i_rst = 1;
    steps(3, 10'h0, 4'hF);
    // Async reset with arbitrary raw inputs
    steps(2, 10'h3FF, 4'h0);
    do_reset();
    steps(8, 10'h0, 4'hF);
    // Switch word latency
    steps(5, 10'h2A5, 4'hF);
    chk("sw_e5", o_io_sw, 32'h0);
    step(10'h2A5, 4'hF);
    chk("sw_e6", o_io_sw, 32'h2A5);
    steps(3, 10'h2A5, 4'hF);
    steps(8, 10'h0, 4'hF);
    // Glitch on switch 0, then a real change
    steps(3, 10'h1, 4'hF);
    steps(6, 10'h0, 4'hF);
    chk("glitch", o_io_sw, 32'h0);
    steps(5, 10'h1, 4'hF);
    chk("sw0_e5", o_io_sw, 32'h0);
    step(10'h1, 4'hF);
    chk("sw0_e6", o_io_sw, 32'h1);
    steps(8, 10'h0, 4'hF);
    // Button 2 press, release, press
    steps(5, 10'h0, 4'hB);
    chk("b2_e5", o_io_btn, 32'h0);
    step(10'h0, 4'hB);
    chk("b2_e6", o_io_btn, 32'h44);
    chk("b2_pulse", 32'(o_btn_press), 32'h4);
    step(10'h0, 4'hB);
    chk("b2_pulse_end", 32'(o_btn_press), 32'h0);
    steps(4, 10'h0, 4'hB);
    steps(6, 10'h0, 4'hF);
    chk("b2_rel", o_io_btn, 32'h40);
    chk("b2_rel_nopulse", 32'(o_btn_press), 32'h0);
    steps(6, 10'h0, 4'hB);
    chk("b2_again", o_io_btn, 32'h04);
    chk("b2_again_pulse", 32'(o_btn_press), 32'h4);
    steps(8, 10'h0, 4'hF);
    // Buttons 0 and 3 together while switch 9 bounces every 2 cycles
    for (int i = 0; i < 6; i++) step(((i / 2) % 2) ? 10'h200 : 10'h0, 4'h6);
    chk("b03_pulse", 32'(o_btn_press), 32'h9);
    chk("b03_btn", o_io_btn, 32'h99);
    chk("sw9_bounce", o_io_sw, 32'h0);
    for (int i = 6; i < 12; i++) step(((i / 2) % 2) ? 10'h200 : 10'h0, 4'h6);
    // Mid-count reset, button 0 held through it
    steps(2, 10'h0, 4'hE);
    do_reset();
    steps(5, 10'h0, 4'hE);
    step(10'h0, 4'hE);
    chk("requal_pulse", 32'(o_btn_press), 32'h1);
    chk("requal_btn", o_io_btn, 32'h11);
    steps(8, 10'h0, 4'hF);
    // Random phase: inputs mostly held, occasional bursts of bit flips
    cur_sw = '0;
    cur_btn = '1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) cur_sw ^= NS'($urandom);
      if ($urandom_range(0, 5) == 0) cur_btn ^= NB'($urandom);
      if (i == 200) do_reset();
      step(cur_sw, cur_btn);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
